// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// IMEM_LOADER_CHECKSUM_EN adds the trailing-checksum state.
package imem_loader_pkg;

  localparam int WORD_BYTES        = 4;
  localparam int LEN_BYTES         = 2;
  localparam int IMEM_SIZE_DEFAULT = 128;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Big-endian byte-to-word shift register with a byte counter.
// The 2-bit counter wraps after the last byte of each word.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  localparam int CNT_W = $clog2(WORD_BYTES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear_i) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (byte_valid_i) begin
      word_d = {word_q[23:0], byte_i};
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word_o      = word_q;
  assign word_full_o = byte_valid_i && (cnt_q == CNT_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> instruction memory writes, holding the CPU in reset until loaded.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned IMEM_SIZE = IMEM_SIZE_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        cpu_rst,
  output logic        done,
  output logic        err
);

  localparam int LEN_W = LEN_BYTES * 8;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e AFTER_LOAD = CHK;
`else
  localparam state_e AFTER_LOAD = DONE;
`endif

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [15:0]        widx_q, widx_d;
  logic               xfer, startTake, wordFull, lastWord;
  logic [LEN_W-1:0]   lenFull;

  assign xfer      = in_valid && in_ready;
  assign startTake = start && (state_q inside {IDLE, DONE, ERR});
  assign lenFull   = {len_q[15:8], in_data};
  assign lastWord  = ((widx_q + 16'd1) == len_q);

  word_assembler u_asm (
    .CLK          (CLK),
    .RST          (RST),
    .clear_i      (startTake),
    .byte_valid_i (xfer && (state_q == DATA)),
    .byte_i       (in_data),
    .word_o       (mem_wdata),
    .word_full_o  (wordFull)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;

  // Running XOR over the length and data bytes; the checksum byte itself is excluded.
  always_comb begin
    chk_d = chk_q;
    if (startTake)
      chk_d = '0;
    else if (xfer && (state_q != CHK))
      chk_d = chk_q ^ in_data;
  end

  always_ff @(posedge CLK) begin
    if (!RST) chk_q <= '0;
    else      chk_q <= chk_d;
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      len_q   <= '0;
      widx_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: if (startTake) state_d = LEN_HI;
      LEN_HI:          if (xfer) state_d = LEN_LO;
      LEN_LO: begin
        if (xfer) begin
          if ({16'd0, lenFull} > IMEM_SIZE) state_d = ERR;
          else if (lenFull == '0)           state_d = AFTER_LOAD;
          else                              state_d = DATA;
        end
      end
      DATA:            if (wordFull) state_d = WRITE;
      WRITE:           state_d = lastWord ? AFTER_LOAD : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:             if (xfer) state_d = (in_data == chk_q) ? DONE : ERR;
`endif
      default:         state_d = IDLE;
    endcase
  end

  // Length capture and word index; the index only advances once a word has been written.
  always_comb begin
    len_d  = len_q;
    widx_d = widx_q;
    if (xfer && (state_q == LEN_HI)) len_d[15:8] = in_data;
    if (xfer && (state_q == LEN_LO)) begin
      len_d[7:0] = in_data;
      widx_d     = '0;
    end
    if ((state_q == WRITE) && !lastWord) widx_d = widx_q + 16'd1;
  end

  always_comb begin
    in_ready = 1'b0;
    mem_we   = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    cpu_rst  = 1'b1;
    case (state_q)
      LEN_HI, LEN_LO, DATA: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:                  in_ready = 1'b1;
`endif
      WRITE:                mem_we = 1'b1;
      DONE: begin
        done    = 1'b1;
        cpu_rst = 1'b0;
      end
      ERR:                  err = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr = {14'd0, widx_q, 2'b00};

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued per image, observed writes captured each cycle.
// Checksum scenarios are compiled in when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mem_we, cpu_rst, done, err;
  logic [31:0] mem_addr, mem_wdata;

  wr_t         expQ[$];
  wr_t         obsQ[$];
  logic [7:0]  imgQ[$];
  logic [31:0] wordQ[$];
  int          assertions = 0;
  int          failures = 0;

  always #5 CLK = ~CLK;

  imem_loader dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .err       (err)
  );

  // Every cycle ends 1 time unit after the edge; any write strobe seen then is recorded.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (mem_we === 1'b1) obsQ.push_back({mem_addr, mem_wdata});
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit gap);
    bit acc;
    int budget;
    if (gap) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    budget   = 0;
    do begin
      acc = (in_ready === 1'b1);
      tick();
      budget++;
    end while (!acc && budget < 40);
    if (!acc) begin
      assertions++;
      failures++;
      $display("[TB] FAIL byte_accept_timeout: byte %02h got in_ready=%b, required acceptance within 40 cycles", b, in_ready);
    end
  endtask

  task automatic buildImage();
    logic [15:0] n;
    n = 16'(wordQ.size());
    imgQ.delete();
    imgQ.push_back(n[15:8]);
    imgQ.push_back(n[7:0]);
    foreach (wordQ[i]) begin
      for (int b = 3; b >= 0; b--) imgQ.push_back(wordQ[i][8*b +: 8]);
      expQ.push_back({32'(i) << 2, wordQ[i]});
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      foreach (imgQ[i]) x ^= imgQ[i];
      imgQ.push_back(x);
    end
`endif
  endtask

  task automatic sendImage(input bit gaps);
    foreach (imgQ[i]) sendByte(imgQ[i], gaps);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) tick();
    assertions++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready: got %b, want 0", in_ready); end
    assertions++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_we: got %b, want 0", mem_we); end
    assertions++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b, want 0", done); end
    assertions++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b, want 0", err); end
    assertions++; if (mem_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_mem_addr: got %h, want 0", mem_addr); end
    assertions++; if (mem_wdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_mem_wdata: got %h, want 0", mem_wdata); end
    assertions++; if (cpu_rst !== 1'b1) begin failures++; $display("[TB] FAIL reset_cpu_rst: got %b, want 1", cpu_rst); end
    RST = 1'b1;
    tick();
    obsQ.delete();
  endtask

  task automatic test_basic_load();
    wr_t e, o;
    pulseStart();
    wordQ = '{32'h12345678, 32'h9ABCDEF0};
    buildImage();
    foreach (imgQ[i]) begin
      sendByte(imgQ[i], 1'b0);
      if (i == 5) begin
        assertions++; if (mem_we !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("[TB] FAIL basic_write_cycle: mem_we=%b in_ready=%b, want 1/0", mem_we, in_ready); end
      end
      if (i == 9) begin
        assertions++; if (done !== 1'b0 || cpu_rst !== 1'b1) begin failures++; $display("[TB] FAIL basic_final_write: done=%b cpu_rst=%b, want 0/1", done, cpu_rst); end
`ifndef IMEM_LOADER_CHECKSUM_EN
        tick();
        assertions++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL basic_done_timing: done=%b, want 1 after final write", done); end
`endif
      end
    end
    in_valid = 1'b0;
    repeat (3) tick();
    assertions++; if (obsQ.size() !== expQ.size()) begin failures++; $display("[TB] FAIL basic_write_count: got %0d, want %0d", obsQ.size(), expQ.size()); end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      assertions++; if (o !== e) begin failures++; $display("[TB] FAIL basic_write: got addr %h data %h, want addr %h data %h", o.addr, o.data, e.addr, e.data); end
    end
    expQ.delete(); obsQ.delete();
    assertions++; if (done !== 1'b1 || cpu_rst !== 1'b0 || err !== 1'b0) begin failures++; $display("[TB] FAIL basic_end_state: done=%b cpu_rst=%b err=%b, want 1/0/0", done, cpu_rst, err); end
  endtask

  task automatic test_len_overflow();
    pulseStart();
    assertions++; if (done !== 1'b0 || cpu_rst !== 1'b1 || in_ready !== 1'b1) begin failures++; $display("[TB] FAIL restart_from_done: done=%b cpu_rst=%b in_ready=%b, want 0/1/1", done, cpu_rst, in_ready); end
    sendByte(8'h00, 1'b0);
    sendByte(8'h81, 1'b0);
    in_valid = 1'b0;
    assertions++; if (err !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("[TB] FAIL overflow_err: err=%b cpu_rst=%b done=%b in_ready=%b, want 1/1/0/0", err, cpu_rst, done, in_ready); end
    repeat (4) tick();
    assertions++; if (obsQ.size() !== 0) begin failures++; $display("[TB] FAIL overflow_no_write: got %0d writes, want 0", obsQ.size()); end
    obsQ.delete();
  endtask

  task automatic test_backpressure();
    wr_t e, o;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    wordQ = '{32'h12345678, 32'h9ABCDEF0};
    buildImage();
    sendImage(1'b1);
    repeat (3) tick();
    assertions++; if (obsQ.size() !== expQ.size()) begin failures++; $display("[TB] FAIL bp_write_count: got %0d, want %0d", obsQ.size(), expQ.size()); end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      assertions++; if (o !== e) begin failures++; $display("[TB] FAIL bp_write: got addr %h data %h, want addr %h data %h", o.addr, o.data, e.addr, e.data); end
    end
    expQ.delete(); obsQ.delete();
    assertions++; if (done !== 1'b1 || err !== 1'b0) begin failures++; $display("[TB] FAIL bp_end_state: done=%b err=%b, want 1/0", done, err); end
  endtask

  task automatic test_zero_len();
    pulseStart();
    wordQ.delete();
    buildImage();
    sendImage(1'b0);
    assertions++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin failures++; $display("[TB] FAIL zero_len_done: done=%b cpu_rst=%b, want 1/0", done, cpu_rst); end
    repeat (3) tick();
    assertions++; if (obsQ.size() !== 0) begin failures++; $display("[TB] FAIL zero_len_no_write: got %0d writes, want 0", obsQ.size()); end
    obsQ.delete();
  endtask

  task automatic test_max_len();
    wr_t e, o;
    pulseStart();
    wordQ.delete();
    for (int i = 0; i < 128; i++) wordQ.push_back($urandom);
    buildImage();
    sendImage(1'b0);
    repeat (3) tick();
    assertions++; if (obsQ.size() !== expQ.size()) begin failures++; $display("[TB] FAIL max_write_count: got %0d, want %0d", obsQ.size(), expQ.size()); end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      assertions++; if (o !== e) begin failures++; $display("[TB] FAIL max_write: got addr %h data %h, want addr %h data %h", o.addr, o.data, e.addr, e.data); end
    end
    expQ.delete(); obsQ.delete();
    assertions++; if (done !== 1'b1 || err !== 1'b0) begin failures++; $display("[TB] FAIL max_end_state: done=%b err=%b, want 1/0", done, err); end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    wr_t e, o;
    for (int pass = 0; pass < 2; pass++) begin
      pulseStart();
      imgQ = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
      if (pass == 1) imgQ[6] = 8'h08;
      expQ.push_back({32'h0, 32'h12345678});
      sendImage(1'b0);
      repeat (2) tick();
      assertions++; if (obsQ.size() !== 1) begin failures++; $display("[TB] FAIL chk_write_count pass %0d: got %0d, want 1", pass, obsQ.size()); end
      while (expQ.size() > 0 && obsQ.size() > 0) begin
        e = expQ.pop_front();
        o = obsQ.pop_front();
        assertions++; if (o !== e) begin failures++; $display("[TB] FAIL chk_write pass %0d: got addr %h data %h, want addr %h data %h", pass, o.addr, o.data, e.addr, e.data); end
      end
      expQ.delete(); obsQ.delete();
      assertions++; if (done !== (pass == 0) || err !== (pass == 1)) begin failures++; $display("[TB] FAIL chk_result pass %0d: done=%b err=%b, want %b/%b", pass, done, err, pass == 0, pass == 1); end
    end
  endtask
`endif

  task automatic test_mid_reset();
    wr_t e, o;
    pulseStart();
    sendByte(8'h00, 1'b0);
    sendByte(8'h02, 1'b0);
    sendByte(8'h12, 1'b0);
    sendByte(8'h34, 1'b0);
    in_valid = 1'b0;
    RST = 1'b0;
    tick();
    assertions++; if (in_ready !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin failures++; $display("[TB] FAIL midrst_flags: in_ready=%b mem_we=%b done=%b err=%b, want 0/0/0/0", in_ready, mem_we, done, err); end
    assertions++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || cpu_rst !== 1'b1) begin failures++; $display("[TB] FAIL midrst_data: addr=%h wdata=%h cpu_rst=%b, want 0/0/1", mem_addr, mem_wdata, cpu_rst); end
    RST = 1'b1;
    repeat (2) tick();
    assertions++; if (obsQ.size() !== 0) begin failures++; $display("[TB] FAIL midrst_no_write: got %0d writes, want 0", obsQ.size()); end
    obsQ.delete();
    pulseStart();
    wordQ = '{32'hCAFEBABE, 32'h01020304};
    buildImage();
    sendImage(1'b0);
    repeat (3) tick();
    assertions++; if (obsQ.size() !== expQ.size()) begin failures++; $display("[TB] FAIL midrst_write_count: got %0d, want %0d", obsQ.size(), expQ.size()); end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      assertions++; if (o !== e) begin failures++; $display("[TB] FAIL midrst_write: got addr %h data %h, want addr %h data %h", o.addr, o.data, e.addr, e.data); end
    end
    expQ.delete(); obsQ.delete();
    assertions++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL midrst_done: got %b, want 1", done); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_len_overflow();
    test_backpressure();
    test_zero_len();
    test_max_len();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader directly upstream of the single-cycle MIPS instruction memory. It receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and drives the instruction memory write port (byte address, write data, write enable) one word at a time. It holds the CPU in reset until the whole image is written, then releases it.

## Interface
- IMEM_SIZE, 128: instruction memory depth in 32-bit words; the largest accepted word count.
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  reset, synchronous, active-low.
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR; ignored in any other state.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_addr  output  32  byte address to instruction memory, always word index << 2.
- mem_wdata  output  32  assembled instruction word.
- mem_we  output  1  write strobe, one cycle per word.
- cpu_rst  output  1  active-high reset to the CPU and instruction memory read side.
- done  output  1  image fully written.
- err  output  1  load aborted.

## Operation
- Byte transfer occurs on a rising edge with in_valid && in_ready; no other byte is consumed.
- Stream format: LEN_HI, LEN_LO (16-bit word count N), then N words of 4 bytes each, MSB first; with checksum enabled, one trailing checksum byte follows.
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK (checksum builds only), DONE, ERR.
- IDLE --start--> LEN_HI. LEN_HI --byte--> LEN_LO. LEN_LO --byte--> evaluate N.
- After LEN_LO: N > IMEM_SIZE -> ERR. N == 0 -> CHK, or DONE without checksum. Otherwise -> DATA, with the word index cleared to 0.
- DATA shifts each byte into mem_wdata (mem_wdata <= {mem_wdata[23:0], byte}) and counts bytes 0..3. The 4th byte moves the block to WRITE.
- WRITE asserts mem_we for exactly one cycle at the current mem_addr.
  - If more words remain, the next state is DATA and the word index increments, so mem_addr advances by 4.
  - After word N-1, the next state is CHK, or DONE without checksum.
- DONE: done=1, cpu_rst=0. ERR: err=1, cpu_rst=1. Both states persist until start or reset.
- start from DONE or ERR clears done, clears err, sets cpu_rst=1 and enters LEN_HI.
- in_ready=1 only in LEN_HI, LEN_LO, DATA and CHK.
- Word index is 16 bits wide. The address wraps cannot occur because N ≤ IMEM_SIZE.

## Timing
- Reset values:
  - state=IDLE
  - in_ready=0, mem_we=0, done=0, err=0
  - mem_addr=0, mem_wdata=0
  - cpu_rst=1
- RST low at any cycle, mid-load included, returns every output to its reset value at that edge. No further mem_we is issued, and the partially assembled word is discarded.
- If the 4th byte of a word is accepted at edge k, mem_we is high in cycle k+1 and in_ready is low in cycle k+1. The next byte can be accepted at edge k+2 at the earliest.
- mem_addr and mem_wdata are stable for the whole cycle in which mem_we=1.
- Peak throughput is one word per 5 cycles; arbitrary in_valid gaps only stretch the load.
- done and cpu_rst change in the cycle after the final WRITE (or after CHK, or after LEN_LO when N=0).
- start and a byte in the same cycle in IDLE, DONE or ERR: start is taken and the byte is not consumed, because in_ready=0.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined: the CHK state exists.
  - A running XOR covers all bytes from LEN_HI through the last data byte.
  - The trailing byte must equal that XOR. If it matches, the next state is DONE; if it does not, the next state is ERR.
- Undefined: no CHK state and no XOR register; the final WRITE goes straight to DONE.

## Structure
- Package imem_loader_pkg holds:
  - the state enum typedef
  - WORD_BYTES=4 and LEN_BYTES=2
  - the default IMEM_SIZE
- Sub-module word_assembler owns the 32-bit shift register and the 2-bit byte counter. It reports word_full when the 4th byte is accepted and clears on start or RST.

## Test plan
- Reset check: hold RST=0 for 3 cycles -> in_ready=0, mem_we=0, done=0, err=0, mem_addr=0, mem_wdata=0, cpu_rst=1.
- Basic load: start, then bytes 00 02 12 34 56 78 9A BC DE F0 with no gaps, checksum disabled.
  - mem_we pulse 1 carries addr 0x0 and data 0x12345678; pulse 2 carries addr 0x4 and data 0x9ABCDEF0.
  - Afterwards done=1 and cpu_rst=0.
- Length overflow: start, then bytes 00 81 (N=129, IMEM_SIZE=128) -> err=1 the cycle after LEN_LO, no mem_we, cpu_rst=1.
- Backpressure: repeat the basic load with in_valid toggling every cycle, and with a byte offered during WRITE. The result must be identical writes with no lost or duplicated byte.
- Checksum (IMEM_LOADER_CHECKSUM_EN): bytes 00 01 12 34 56 78.
  - Trailing 09 -> done=1.
  - Trailing 08 -> err=1; the single word has still been written at addr 0.
- Mid-load reset: drive RST=0 after 00 02 12 34 -> all outputs return to reset values. A new start followed by a full image then writes from addr 0.
